// File: rtl/vga_bus_ctrl.sv
// vga_bus_ctrl: bus peripheral between the 8-bit processor bus and the VGA
// frame-buffer wrapper. Provides X/Y pixel access, the colour configuration
// register and a full-frame hardware fill engine.
// Optional build macro VGA_FILL_IRQ_EN adds a one-cycle IRQ pulse when a fill completes.
module vga_bus_ctrl #(
    parameter logic [7:0]  BASE_ADDR  = 8'hB0,
    parameter int          H_PIXELS   = 160,
    parameter int          V_PIXELS   = 120,
    parameter logic [15:0] COLOUR_RST = 16'hFF00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  BUS_ADDR,
    input  logic [7:0]  BUS_DATA_IN,
    input  logic        BUS_WE,
    output logic [7:0]  BUS_DATA_OUT,
    output logic        BUS_DATA_OE,
    output logic [14:0] A_ADDR,
    output logic        A_DATA_IN,
    output logic        A_WE,
    input  logic        FB_RD_DATA,
    output logic [15:0] CONFIG_COLOURS,
    output logic        BUSY
`ifdef VGA_FILL_IRQ_EN
    ,
    output logic        IRQ
`endif
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [7:0] H_LIM   = 8'(H_PIXELS);
    localparam logic [6:0] V_LIM   = 7'(V_PIXELS);
    localparam logic [7:0] FX_LAST = 8'(H_PIXELS - 1);
    localparam logic [6:0] FY_LAST = 7'(V_PIXELS - 1);

    state_t      state, next_state;
    logic [7:0]  x_reg;
    logic [6:0]  y_reg;
    logic [7:0]  fx;
    logic [6:0]  fy;
    logic        fill_val;
    logic        pix_we;
    logic        pix_data;
    logic [7:0]  offset;
    logic        in_range;
    logic        wr;
    logic        rd;
    logic        fill_start;
    logic        fill_last;
    logic [7:0]  rd_mux;

    // Address decode: registers live at BASE_ADDR+0 .. BASE_ADDR+5.
    assign offset     = BUS_ADDR - BASE_ADDR;
    assign in_range   = (offset < 8'd6);
    assign wr         = in_range && BUS_WE;
    assign rd         = in_range && !BUS_WE;
    assign fill_start = wr && (offset == 8'd5) && BUS_DATA_IN[0] && (state == IDLE);
    assign fill_last  = (state == FILL) && (fx == FX_LAST) && (fy == FY_LAST);

    // State register for the fill engine.
    // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and frame-buffer port drive; the sweep owns the A-port while filling.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        BUSY       = 1'b0;
        A_WE       = pix_we;
        A_DATA_IN  = pix_data;
        A_ADDR     = {y_reg, x_reg};
        case (state)
            IDLE: if (fill_start) next_state = FILL;
            FILL: begin
                BUSY      = 1'b1;
                A_WE      = 1'b1;
                A_DATA_IN = fill_val;
                A_ADDR    = {fy, fx};
                if (fill_last) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Register writes, pixel-write strobe and fill sweep counters.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            x_reg          <= 8'd0;
            y_reg          <= 7'd0;
            CONFIG_COLOURS <= COLOUR_RST;
            pix_we         <= 1'b0;
            pix_data       <= 1'b0;
            fill_val       <= 1'b0;
            fx             <= 8'd0;
            fy             <= 7'd0;
        end else begin
            pix_we <= 1'b0;
            if (wr) begin
                case (offset)
                    8'd0: x_reg <= BUS_DATA_IN;
                    8'd1: y_reg <= BUS_DATA_IN[6:0];
                    8'd2: if (state == IDLE && x_reg < H_LIM && y_reg < V_LIM) begin
                        pix_we   <= 1'b1;
                        pix_data <= BUS_DATA_IN[0];
                    end
                    8'd3: CONFIG_COLOURS[7:0]  <= BUS_DATA_IN;
                    8'd4: CONFIG_COLOURS[15:8] <= BUS_DATA_IN;
                    8'd5: if (fill_start) fill_val <= BUS_DATA_IN[1];
                    default: ;
                endcase
            end
            if (fill_start) begin
                fx <= 8'd0;
                fy <= 7'd0;
            end else if (state == FILL) begin
                if (fx == FX_LAST) begin
                    fx <= 8'd0;
                    fy <= fy + 7'd1;
                end else begin
                    fx <= fx + 8'd1;
                end
            end
        end
    end

    // Read-data selection for the addressed register.
    always_comb begin
        rd_mux = 8'd0;
        case (offset)
            8'd0: rd_mux = x_reg;
            8'd1: rd_mux = {1'b0, y_reg};
            8'd2: rd_mux = {7'd0, FB_RD_DATA};
            8'd3: rd_mux = CONFIG_COLOURS[7:0];
            8'd4: rd_mux = CONFIG_COLOURS[15:8];
            8'd5: rd_mux = {7'd0, BUSY};
            default: rd_mux = 8'd0;
        endcase
    end

    // Registered read port: data and OE appear one cycle after the address.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            BUS_DATA_OUT <= 8'd0;
            BUS_DATA_OE  <= 1'b0;
        end else begin
            BUS_DATA_OE  <= rd;
            BUS_DATA_OUT <= rd ? rd_mux : 8'd0;
        end
    end

`ifdef VGA_FILL_IRQ_EN
    // Completion interrupt: high in the first cycle after the last fill pixel.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) IRQ <= 1'b0;
        else        IRQ <= fill_last;
    end
`endif

endmodule

// File: tb/tb_vga_bus_ctrl.sv
// Directed self-checking bench for vga_bus_ctrl, with a behavioural frame buffer
// providing one-cycle registered read data on the A-port.
`timescale 1ns/1ps
module tb_vga_bus_ctrl;

    localparam logic [7:0] BASE = 8'hB0;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [7:0]  BUS_ADDR = 8'h00;
    logic [7:0]  BUS_DATA_IN = 8'h00;
    logic        BUS_WE = 1'b0;
    logic [7:0]  BUS_DATA_OUT;
    logic        BUS_DATA_OE;
    logic [14:0] A_ADDR;
    logic        A_DATA_IN;
    logic        A_WE;
    logic        FB_RD_DATA = 1'b0;
    logic [15:0] CONFIG_COLOURS;
    logic        BUSY;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    bit fb [32768];

    always #5 CLK = ~CLK;

    vga_bus_ctrl dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .BUS_ADDR       (BUS_ADDR),
        .BUS_DATA_IN    (BUS_DATA_IN),
        .BUS_WE         (BUS_WE),
        .BUS_DATA_OUT   (BUS_DATA_OUT),
        .BUS_DATA_OE    (BUS_DATA_OE),
        .A_ADDR         (A_ADDR),
        .A_DATA_IN      (A_DATA_IN),
        .A_WE           (A_WE),
        .FB_RD_DATA     (FB_RD_DATA),
        .CONFIG_COLOURS (CONFIG_COLOURS),
        .BUSY           (BUSY)
`ifdef VGA_FILL_IRQ_EN
        ,
        .IRQ            (IRQ)
`endif
    );

`ifndef VGA_FILL_IRQ_EN
    assign IRQ = 1'b0;
`endif

    // Behavioural frame buffer: write on A_WE, registered read of A_ADDR.
    always @(posedge CLK) begin
        if (A_WE === 1'b1) fb[A_ADDR] <= A_DATA_IN;
        FB_RD_DATA <= fb[A_ADDR];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        BUS_ADDR = a; BUS_DATA_IN = d; BUS_WE = 1'b1;
        @(negedge CLK);
        BUS_ADDR = 8'h00; BUS_DATA_IN = 8'h00; BUS_WE = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
        @(negedge CLK);
        BUS_ADDR = a; BUS_WE = 1'b0;
        @(negedge CLK);
        BUS_ADDR = 8'h00;
        d  = BUS_DATA_OUT;
        oe = BUS_DATA_OE;
    endtask

    initial begin
        logic [7:0]  d;
        logic        oe;
        int          n, we_cnt, data_bad, irq_mid;
        logic [14:0] first_a, a161, last_a;
        bit          done;

        // Reset state
        #12;
        check("rst_oe", BUS_DATA_OE, 1'b0);
        check("rst_awe", A_WE, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_colours", CONFIG_COLOURS, 16'hFF00);
        check("rst_aaddr", A_ADDR, 15'h0000);
        @(negedge CLK);
        RESET = 1'b1;

        // Colour register readback after reset
        bus_read(BASE + 8'd3, d, oe);
        check("rd3_oe", oe, 1'b1);
        check("rd3_data", d, 8'h00);
        @(negedge CLK);
        check("rd3_oe_drop", BUS_DATA_OE, 1'b0);
        bus_read(BASE + 8'd4, d, oe);
        check("rd4_oe", oe, 1'b1);
        check("rd4_data", d, 8'hFF);
        check("rd_awe_idle", A_WE, 1'b0);

        // Pixel write at (5,7) and readback
        bus_write(BASE + 8'd0, 8'd5);
        bus_write(BASE + 8'd1, 8'd7);
        bus_write(BASE + 8'd2, 8'h01);
        check("pix_awe", A_WE, 1'b1);
        check("pix_addr", A_ADDR, 15'h0705);
        check("pix_data", A_DATA_IN, 1'b1);
        @(negedge CLK);
        check("pix_awe_one", A_WE, 1'b0);
        @(negedge CLK);
        bus_read(BASE + 8'd2, d, oe);
        check("pix_rd_oe", oe, 1'b1);
        check("pix_rd", d, 8'h01);

        // Clipping on X and on Y
        bus_write(BASE + 8'd0, 8'd160);
        bus_write(BASE + 8'd1, 8'd0);
        bus_write(BASE + 8'd2, 8'h01);
        check("clip_x", A_WE, 1'b0);
        bus_write(BASE + 8'd1, 8'd120);
        bus_write(BASE + 8'd0, 8'd0);
        bus_write(BASE + 8'd2, 8'h01);
        check("clip_y", A_WE, 1'b0);
        bus_write(BASE + 8'd0, 8'd159);
        bus_write(BASE + 8'd1, 8'd119);
        bus_write(BASE + 8'd2, 8'h01);
        check("edge_awe", A_WE, 1'b1);
        check("edge_addr", A_ADDR, 15'h779F);

        // Y bit 7 ignored
        bus_write(BASE + 8'd1, 8'hFF);
        bus_read(BASE + 8'd1, d, oe);
        check("y_bit7", d, 8'h7F);

        // Colour bytes are independent
        bus_write(BASE + 8'd3, 8'h5A);
        check("col_lo", CONFIG_COLOURS, 16'hFF5A);
        bus_write(BASE + 8'd4, 8'h3C);
        check("col_hi", CONFIG_COLOURS, 16'h3C5A);
        bus_read(BASE + 8'd3, d, oe);
        check("col_lo_rd", d, 8'h5A);

        // Out-of-range addresses
        bus_write(BASE + 8'd0, 8'd3);
        bus_write(BASE + 8'd1, 8'd3);
        bus_read(8'hB6, d, oe);
        check("oor_b6_oe", oe, 1'b0);
        bus_read(8'hAF, d, oe);
        check("oor_af_oe", oe, 1'b0);
        bus_write(8'hB6, 8'h01);
        check("oor_b6_awe", A_WE, 1'b0);
        bus_write(8'hAF, 8'h77);
        check("oor_af_awe", A_WE, 1'b0);
        bus_read(BASE + 8'd0, d, oe);
        check("oor_x", d, 8'd3);
        bus_read(BASE + 8'd1, d, oe);
        check("oor_y", d, 8'd3);
        check("oor_col", CONFIG_COLOURS, 16'h3C5A);

        // Full fill with value 1, mid-fill pixel write and fill command
        bus_write(BASE + 8'd5, 8'h03);
        n = 0; we_cnt = 0; data_bad = 0; irq_mid = 0; done = 1'b0;
        first_a = '0; a161 = '0; last_a = '0;
        for (int i = 0; i < 20000 && !done; i++) begin
            if (BUSY === 1'b1) begin
                n++;
                if (A_WE === 1'b1) we_cnt++;
                if (A_DATA_IN !== 1'b1) data_bad++;
                if (IRQ === 1'b1) irq_mid++;
                if (n == 1) first_a = A_ADDR;
                if (n == 161) a161 = A_ADDR;
                last_a = A_ADDR;
                if (n == 50) begin
                    BUS_ADDR = BASE + 8'd2; BUS_DATA_IN = 8'h00; BUS_WE = 1'b1;
                end else if (n == 51) begin
                    BUS_ADDR = BASE + 8'd5; BUS_DATA_IN = 8'h01; BUS_WE = 1'b1;
                end else if (n == 52) begin
                    BUS_ADDR = 8'h00; BUS_DATA_IN = 8'h00; BUS_WE = 1'b0;
                end
                @(negedge CLK);
            end else begin
                done = 1'b1;
            end
        end
        check("fill_done", done, 1'b1);
        check("fill_cycles", n, 19200);
        check("fill_we_cnt", we_cnt, 19200);
        check("fill_data_bad", data_bad, 0);
        check("fill_first", first_a, 15'h0000);
        check("fill_wrap", a161, 15'h0100);
        check("fill_last", last_a, 15'h779F);
        check("fill_end_awe", A_WE, 1'b0);
`ifdef VGA_FILL_IRQ_EN
        check("irq_mid", irq_mid, 0);
        check("irq_pulse", IRQ, 1'b1);
        @(negedge CLK);
        check("irq_one", IRQ, 1'b0);
`endif
        bus_read(BASE + 8'd5, d, oe);
        check("busy_rd", d, 8'h00);
        bus_read(BASE + 8'd2, d, oe);
        check("fill_px_rd", d, 8'h01);

        // Reset in the middle of a fill
        bus_write(BASE + 8'd5, 8'h01);
        repeat (99) @(negedge CLK);
        check("mid_busy", BUSY, 1'b1);
        #2 RESET = 1'b0;
        #1;
        check("abort_busy", BUSY, 1'b0);
        check("abort_awe", A_WE, 1'b0);
        check("abort_irq", IRQ, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("post_busy", BUSY, 1'b0);
        check("post_awe", A_WE, 1'b0);
        check("post_colours", CONFIG_COLOURS, 16'hFF00);
        check("post_aaddr", A_ADDR, 15'h0000);
`ifdef VGA_FILL_IRQ_EN
        check("post_irq", IRQ, 1'b0);
`endif
        bus_read(BASE + 8'd5, d, oe);
        check("post_busy_rd", d, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_bus_ctrl.md
Name: vga_bus_ctrl

Overview:
- Memory-mapped bus peripheral between the 8-bit microprocessor bus and the VGA top wrapper; drives the wrapper's A-port (A_ADDR, A_DATA_IN, A_WE) and CONFIG_COLOURS_IN.
- Converts processor register accesses into X/Y pixel writes and pixel reads.
- Holds the 16-bit colour configuration.
- Contains a hardware fill engine that sweeps the visible 160x120 frame so the processor does not clear the screen pixel by pixel.

Parameters:
- BASE_ADDR, 8'hB0, bus base address; registers occupy BASE_ADDR+0 .. BASE_ADDR+5.
- H_PIXELS, 160, visible width; X must be below this.
- V_PIXELS, 120, visible height; Y must be below this.
- COLOUR_RST, 16'hFF00, reset value of CONFIG_COLOURS.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous reset, active-low.
- BUS_ADDR  in  8  processor bus address.
- BUS_DATA_IN  in  8  processor write data.
- BUS_WE  in  1  write strobe, one cycle per write; BUS_WE=0 with a matching address is a read.
- BUS_DATA_OUT  out  8  read data.
- BUS_DATA_OE  out  1  read-data valid / drive enable.
- A_ADDR  out  15  frame-buffer address {Y[6:0], X[7:0]}.
- A_DATA_IN  out  1  frame-buffer write data.
- A_WE  out  1  frame-buffer write enable.
- FB_RD_DATA  in  1  frame-buffer A-port read data, one-cycle registered latency.
- CONFIG_COLOURS  out  16  colour configuration to the wrapper.
- BUSY  out  1  fill engine active.

Behaviour:
- Clock and reset: single clock CLK. RESET is asynchronous, active-low; all flops clear immediately on RESET=0.
- Reset values: X=0, Y=0, CONFIG_COLOURS=COLOUR_RST, BUS_DATA_OUT=0, BUS_DATA_OE=0, A_WE=0, A_DATA_IN=0, BUSY=0, state=IDLE.
- Register map (offset from BASE_ADDR):
  - +0: X, 8 bits, read/write.
  - +1: Y, 7 bits, read/write; bit7 is written as ignored and reads as 0.
  - +2 write: pixel write of BUS_DATA_IN[0] at {Y,X}.
  - +2 read: returns {7'b0, FB_RD_DATA}.
  - +3: CONFIG_COLOURS[7:0], read/write.
  - +4: CONFIG_COLOURS[15:8], read/write.
  - +5 write: command; bit0=1 starts a fill, bit1 is the fill value.
  - +5 read: {7'b0, BUSY}.
- Addresses outside BASE_ADDR..BASE_ADDR+5: no effect, BUS_DATA_OE stays 0.
- Reads: BUS_DATA_OE and BUS_DATA_OUT are registered and valid exactly one cycle after the read address is presented. OE returns to 0 the following cycle unless the read continues.
- A_ADDR when IDLE: continuously {Y,X}. A pixel read returns the correct value only when at least 2 cycles have passed since the last X/Y write; earlier reads return the previous pixel.
- Pixel write:
  - Registered. A_WE=1 for exactly one cycle, the cycle after the bus write.
  - A_DATA_IN = BUS_DATA_IN[0], A_ADDR = {Y,X}.
  - Clipping: if X>=H_PIXELS or Y>=V_PIXELS, A_WE stays 0 and the write is dropped silently.
- State machine:
  - IDLE -> FILL on a +5 write with bit0=1: latch the fill value, set fill counters fx=0, fy=0, set BUSY=1 in the next cycle.
  - FILL: A_WE=1, A_ADDR={fy,fx}, A_DATA_IN=fill value, one pixel per cycle. fx increments; at fx=H_PIXELS-1 it wraps to 0 and fy increments.
  - FILL -> IDLE after the pixel {V_PIXELS-1, H_PIXELS-1} is written. BUSY and A_WE drop in the next cycle. A full fill is exactly 19200 A_WE cycles.
- While BUSY:
  - Pixel writes (+2) are dropped.
  - Fill commands are ignored.
  - X/Y/colour writes update their registers but do not disturb the sweep.
  - Reads of +2 return undefined data; reads of all other registers are valid.
- Reset asserted mid-fill: the engine aborts immediately and BUSY=0. Pixels already written stay in the frame buffer.
- Colour writes take effect on CONFIG_COLOURS the cycle after the bus write. The two bytes are independent.

Optional Feature:
- Macro: VGA_FILL_IRQ_EN.
- With the macro defined:
  - Extra output port IRQ, 1 bit, reset 0.
  - IRQ pulses high for exactly one cycle, the cycle in which BUSY falls at fill completion.
  - No pulse when a fill is aborted by reset.
- Without the macro: the IRQ port does not exist, and the fill-completion logic carries no interrupt flop.

Test Plan:
- Reset, then read +3 and +4: BUS_DATA_OUT=8'h00 then 8'hFF, each with OE one cycle after the address. A_WE=0 throughout.
- Write X=5, Y=7, then write +2 with data 1: exactly one A_WE pulse with A_ADDR=15'h0705 and A_DATA_IN=1. After 2 idle cycles, reading +2 returns 8'h01.
- Write X=160, Y=0, then write +2 with data 1: no A_WE pulse (clipped). Write Y=120, X=0, then write +2: also no pulse.
- Write +5 with 8'h03:
  - BUSY=1 for exactly 19200 cycles, A_WE=1 in every one of them.
  - First address is 15'h0000, address after X=159 is 15'h0100, last address is 15'h779F, A_DATA_IN=1 throughout.
  - A +2 write issued mid-fill produces no extra A_WE.
  - With VGA_FILL_IRQ_EN defined, a single IRQ pulse at the end.
- Start a fill, assert RESET=0 at cycle 100: BUSY, A_WE and IRQ go to 0 asynchronously. After release the block is IDLE and CONFIG_COLOURS=16'hFF00.
- Read address BASE_ADDR+6 and 8'hAF: OE stays 0. Writes to them change no register and produce no A_WE.
